// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard-unit enables, ID branch redirect, instruction memory and IF/ID outputs.
// master is the fetch stage itself; slave is the surrounding core/memory.
interface fetch_stage_if;
  logic        pc_write;
  logic        if_id_write;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] stall_cnt;

  modport master (
    input  pc_write, if_id_write, branch_taken, branch_target, imem_data,
    output imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, stall_cnt
  );

  modport slave (
    output pc_write, if_id_write, branch_taken, branch_target, imem_data,
    input  imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, stall_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with branch flush, hazard stalls and HLT drain/halt.
// Optional stall-cycle counter built only when FETCH_STALL_CNT_EN is defined.
module fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [15:0] BUBBLE       = 16'h0000
) (
  input logic          clk,
  input logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next, pc_plus2, target_even;
  logic [3:0]  drain_cnt, drain_next;
  logic        hlt_fetch, redirect;
  logic        ifid_load, ifid_flush, stall_inc;
  logic [15:0] instr_p1, pc_plus2_p1;
  logic        vld_p1;
  logic        halted_q;

  assign pc_plus2    = pc + 16'd2;
  assign target_even = bus.branch_target & 16'hFFFE;
  assign hlt_fetch   = (bus.imem_data[15:12] == 4'hF);
  // A redirect only counts while ID is allowed to advance; otherwise ID re-presents it later.
  assign redirect    = bus.if_id_write && bus.branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (hlt_fetch && bus.if_id_write && !bus.branch_taken) state_next = DRAIN;
      DRAIN:   if (drain_cnt == 4'd0) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_next    = pc;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    stall_inc  = 1'b0;
    drain_next = drain_cnt;
    case (state)
      RUN: begin
        if (redirect) begin
          pc_next    = target_even;
          ifid_flush = 1'b1;
        end else begin
          // The PC never moves past an HLT, so the halt word is latched exactly once.
          if (bus.pc_write && !hlt_fetch) pc_next = pc_plus2;
          ifid_load = bus.if_id_write;
          stall_inc = !bus.pc_write;
        end
        if (state_next == DRAIN) drain_next = 4'(DRAIN_CYCLES - 1);
      end
      DRAIN:   if (drain_cnt != 4'd0) drain_next = drain_cnt - 4'd1;
      default: ;
    endcase
  end

  // ---- IF stage: program counter and drain control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      drain_cnt <= 4'd0;
      halted_q  <= 1'b0;
    end else begin
      pc        <= pc_next;
      drain_cnt <= drain_next;
      halted_q  <= (state_next == HALTED);
    end
  end

  // ---- IF/ID boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p1    <= BUBBLE;
      pc_plus2_p1 <= 16'h0000;
      vld_p1      <= 1'b0;
    end else if (ifid_flush) begin
      instr_p1    <= BUBBLE;
      pc_plus2_p1 <= 16'h0000;
      vld_p1      <= 1'b0;
    end else if (ifid_load) begin
      instr_p1    <= bus.imem_data;
      pc_plus2_p1 <= pc_plus2;
      vld_p1      <= 1'b1;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_q <= 16'h0000;
    else if (stall_inc && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign bus.stall_cnt = stall_q;
`else
  logic unused_stall;
  assign unused_stall  = stall_inc;
  assign bus.stall_cnt = 16'h0000;
`endif

  assign bus.imem_addr      = pc;
  assign bus.if_id_instr    = instr_p1;
  assign bus.if_id_pc_plus2 = pc_plus2_p1;
  assign bus.if_id_valid    = vld_p1;
  assign bus.halted         = halted_q;

endmodule
